// File: rtl/st_demultiplexer.sv
// Two-entry FIFO that routes each accepted beat to one of two outputs by its channel bit,
// in acceptance order, with saturating per-channel delivery counters.
module st_demultiplexer #(
  parameter int DWIDTH = 8,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_channel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DWIDTH-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DWIDTH-1:0] out1_data,
  input  logic              cnt_clr,
  output logic [CNTW-1:0]   cnt0,
  output logic [CNTW-1:0]   cnt1
);

  typedef struct packed {
    logic              ch;
    logic [DWIDTH-1:0] data;
  } entry_t;

  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  entry_t          r_mem [2];
  logic            r_wptr;
  logic            r_rptr;
  logic [1:0]      r_occ;
  logic            r_in_ready;
  logic [CNTW-1:0] r_cnt0;
  logic [CNTW-1:0] r_cnt1;

  entry_t     w_head;
  logic       w_nonempty;
  logic       w_push;
  logic       w_pop0;
  logic       w_pop1;
  logic       w_pop;
  logic [1:0] w_occ_nxt;

  assign w_head     = r_mem[r_rptr];
  assign w_nonempty = (r_occ != 2'd0);

  assign out0_valid = w_nonempty & ~w_head.ch;
  assign out1_valid = w_nonempty &  w_head.ch;
  assign out0_data  = w_nonempty ? w_head.data : '0;
  assign out1_data  = w_nonempty ? w_head.data : '0;
  assign in_ready   = r_in_ready;
  assign cnt0       = r_cnt0;
  assign cnt1       = r_cnt1;

  // Only the ready of the output that owns the head beat can cause a pop.
  assign w_push = in_valid & r_in_ready;
  assign w_pop0 = out0_valid & out0_ready;
  assign w_pop1 = out1_valid & out1_ready;
  assign w_pop  = w_pop0 | w_pop1;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + 2'd1;
      2'b01:   w_occ_nxt = r_occ - 2'd1;
      default: w_occ_nxt = r_occ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_occ      <= 2'd0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_occ      <= w_occ_nxt;
      r_in_ready <= (w_occ_nxt < 2'd2);
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible because
  // valid and data are gated by occ, which is reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{ch: in_channel, data: in_data};
  end

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (cnt_clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_pop0 && (r_cnt0 != CNT_MAX)) r_cnt0 <= r_cnt0 + CNT_ONE;
      if (w_pop1 && (r_cnt1 != CNT_MAX)) r_cnt1 <= r_cnt1 + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_st_demultiplexer.sv
// Scoreboard bench for st_demultiplexer: a queue models the FIFO, counters are modelled
// for a default instance and a CNTW=4 instance sharing the same stimulus.
module tb_st_demultiplexer;

  typedef struct packed {
    logic       ch;
    logic [7:0] data;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, in_channel, out0_ready, out1_ready, cnt_clr;
  logic [7:0] in_data;
  logic       in_ready, out0_valid, out1_valid;
  logic [7:0] out0_data, out1_data;
  logic [15:0] cnt0, cnt1;
  logic       s_in_ready, s_out0_valid, s_out1_valid;
  logic [7:0] s_out0_data, s_out1_data;
  logic [3:0] s_cnt0, s_cnt1;

  int total = 0;
  int bad   = 0;

  beat_t sb[$];
  int    m_cnt0, m_cnt1, m_scnt0, m_scnt1;
  bit    was_up = 1'b0;

  always #5 clk = ~clk;

  st_demultiplexer #(.DWIDTH(8), .CNTW(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_channel(in_channel),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1)
  );

  st_demultiplexer #(.DWIDTH(8), .CNTW(4)) dut_s (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_channel(in_channel),
    .out0_valid(s_out0_valid), .out0_ready(out0_ready), .out0_data(s_out0_data),
    .out1_valid(s_out1_valid), .out1_ready(out1_ready), .out1_data(s_out1_data),
    .cnt_clr(cnt_clr), .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) was_up = reset_n;

  // Monitor: compare DUT outputs with the model, then advance the model by this cycle's handshakes.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      m_cnt0 = 0; m_cnt1 = 0; m_scnt0 = 0; m_scnt1 = 0;
    end else begin
      bit    exp_rdy, ne, pop0, pop1;
      beat_t hd;
      exp_rdy = was_up && (sb.size() < 2);
      ne      = (sb.size() != 0);
      hd      = ne ? sb[0] : '0;
      check("in_ready",     in_ready,     exp_rdy);
      check("s_in_ready",   s_in_ready,   exp_rdy);
      check("out0_valid",   out0_valid,   ne && !hd.ch);
      check("out1_valid",   out1_valid,   ne &&  hd.ch);
      check("out0_data",    out0_data,    hd.data);
      check("out1_data",    out1_data,    hd.data);
      check("s_out0_valid", s_out0_valid, ne && !hd.ch);
      check("s_out1_valid", s_out1_valid, ne &&  hd.ch);
      check("s_out0_data",  s_out0_data,  hd.data);
      check("cnt0",   cnt0,   m_cnt0);
      check("cnt1",   cnt1,   m_cnt1);
      check("s_cnt0", s_cnt0, m_scnt0);
      check("s_cnt1", s_cnt1, m_scnt1);
      pop0 = ne && !hd.ch && out0_ready;
      pop1 = ne &&  hd.ch && out1_ready;
      if (pop0 || pop1) void'(sb.pop_front());
      if (in_valid && exp_rdy) sb.push_back('{ch: in_channel, data: in_data});
      if (cnt_clr) begin
        m_cnt0 = 0; m_cnt1 = 0; m_scnt0 = 0; m_scnt1 = 0;
      end else begin
        if (pop0) begin
          m_cnt0++;
          if (m_scnt0 < 15) m_scnt0++;
        end
        if (pop1) begin
          m_cnt1++;
          if (m_scnt1 < 15) m_scnt1++;
        end
      end
    end
  end

  // Offer one beat until accepted; returns the number of cycles it was offered.
  task automatic send(input logic ch, input logic [7:0] d, output int cycles);
    bit acc = 1'b0;
    cycles = 0;
    in_valid = 1'b1; in_channel = ch; in_data = d;
    while (!acc && cycles < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      cycles++;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_left", sb.size(), 0);
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, tot_cyc, hi;
    reset_n = 1'b0; in_valid = 1'b0; in_channel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0; cnt_clr = 1'b0;

    // Reset state and first ready edge.
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out0_valid", out0_valid, 0);
    check("rst_out1_valid", out1_valid, 0);
    check("rst_cnt0", cnt0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 reset_n = 1'b1;
    #1 check("rel_in_ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    check("rel_in_ready_after_edge", in_ready, 1);

    // Single beat on channel 1.
    out1_ready = 1'b1;
    send(1'b1, 8'hA5, cyc);
    hi = 0;
    repeat (4) begin
      @(negedge clk);
      if (out1_valid) hi++;
    end
    check("single_valid_cycles", hi, 1);
    @(posedge clk); #1;
    check("single_cnt1", cnt1, 1);

    // Backpressure on channel 0.
    pulse_clr();
    out0_ready = 1'b0;
    send(1'b0, 8'h11, cyc);
    send(1'b0, 8'h22, cyc);
    check("bp_in_ready_full", in_ready, 0);
    in_valid = 1'b1; in_channel = 1'b0; in_data = 8'h33;
    repeat (3) begin
      @(negedge clk);
      check("bp_third_blocked", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_head_data", out0_data, 8'h11);
    out0_ready = 1'b1;
    drain(10);
    check("bp_cnt0", cnt0, 2);

    // Head-of-line blocking.
    out0_ready = 1'b0; out1_ready = 1'b1;
    send(1'b0, 8'h01, cyc);
    send(1'b1, 8'h02, cyc);
    repeat (3) @(posedge clk);
    #1;
    check("hol_out1_blocked", out1_valid, 0);
    check("hol_head_data", out0_data, 8'h01);
    out0_ready = 1'b1;
    drain(10);

    // Streaming: 100 alternating beats, one per cycle.
    pulse_clr();
    out0_ready = 1'b1; out1_ready = 1'b1;
    tot_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      send(i[0], 8'(i * 7 + 3), cyc);
      tot_cyc += cyc;
    end
    check("stream_cycles", tot_cyc, 100);
    drain(10);
    check("stream_cnt0", cnt0, 50);
    check("stream_cnt1", cnt1, 50);

    // Saturation on the CNTW=4 instance, then clear coinciding with a pop.
    pulse_clr();
    for (int i = 0; i < 20; i++) send(1'b0, 8'(i), cyc);
    drain(10);
    check("sat_s_cnt0", s_cnt0, 15);
    check("sat_cnt0", cnt0, 20);
    send(1'b0, 8'hEE, cyc);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("clr_pop_cnt0", cnt0, 0);
    check("clr_pop_s_cnt0", s_cnt0, 0);
    check("clr_pop_empty", out0_valid, 0);

    // Reset with the FIFO full.
    out0_ready = 1'b0;
    send(1'b0, 8'h55, cyc);
    send(1'b0, 8'h66, cyc);
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    check("mrst_in_ready", in_ready, 0);
    check("mrst_out0_valid", out0_valid, 0);
    check("mrst_out0_data", out0_data, 0);
    check("mrst_out1_data", out1_data, 0);
    check("mrst_cnt0", cnt0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 reset_n = 1'b1;
    out0_ready = 1'b1; out1_ready = 1'b1;
    @(posedge clk); #1;
    check("mrst_ready_after", in_ready, 1);
    check("mrst_no_stale0", out0_valid, 0);
    repeat (3) @(posedge clk);
    #1 check("mrst_no_stale_later", out0_valid, 0);
    send(1'b1, 8'h77, cyc);
    drain(10);
    check("mrst_cnt1", cnt1, 1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
